// File: rtl/ula_pkg.sv
// Shared definitions for the ALU request arbiter: FSM state encoding,
// ALU operand widths and the cycle counter width.
package ula_pkg;

   localparam int OP_W   = 4;   // ULAop width
   localparam int FC_W   = 6;   // FuncCode width
   localparam int DATA_W = 32;  // operand / result width
   localparam int CNT_W  = 4;   // holds EXEC_CYCLES-1 for EXEC_CYCLES up to 15

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ula_rr_arb2.sv
// Two-way round-robin pick. ptr names the requester served last, so on a tie
// the other one wins. A pending hold (lock) forces the held requester to win
// while it is still requesting.
module ula_rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   input  logic hold,
   input  logic hold_sel,
   output logic any,
   output logic pick
);

   // Select the winner among the active requests
   always_comb begin
      any  = req0 | req1;
      pick = 1'b0;
      if (hold && ((!hold_sel && req0) || (hold_sel && req1))) begin
         pick = hold_sel;
      end else if (req0 && req1) begin
         pick = ~ptr;
      end else if (req1) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
   end

endmodule

// File: rtl/ula_arbiter.sv
// Arbitrates a single shared ALU between a core (requester 0) and a
// coprocessor (requester 1). The winner's operands are latched and held on
// the ALU for EXEC_CYCLES cycles, then the ALU output is captured and the
// winner's done pulses for one cycle.
// Optional feature: define ULA_ARB_LOCK_EN to add lock0/lock1 inputs that let
// the served requester keep the ALU for its next request.
module ula_arbiter
   import ula_pkg::*;
#(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [3:0]  op0,
   input  logic [3:0]  op1,
   input  logic [5:0]  fc0,
   input  logic [5:0]  fc1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
`ifdef ULA_ARB_LOCK_EN
   input  logic        lock0,
   input  logic        lock1,
`endif
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] result,
   output logic        res_zero,
   output logic [3:0]  ula_op,
   output logic [5:0]  ula_fc,
   output logic [31:0] ula_a,
   output logic [31:0] ula_b,
   input  logic [31:0] ula_out,
   input  logic        ula_zero
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic                sel_q;     // requester currently owning the ALU
   logic                ptr_q;     // requester served last
   logic [OP_W-1:0]     op_q;
   logic [FC_W-1:0]     fc_q;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   result_q;
   logic                zero_q;

   logic                any_req;
   logic                pick;
   logic                start;     // IDLE -> EXEC this edge
   logic                capture;   // EXEC -> DONE this edge
   logic                release_op;// DONE -> IDLE this edge
   logic                hold;
   logic                lock_sel;

`ifdef ULA_ARB_LOCK_EN
   logic                hold_q;

   assign lock_sel = sel_q ? lock1 : lock0;
   assign hold     = hold_q;

   // Remember a lock taken in DONE until the next operation starts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 1'b0;
      end else if (release_op) begin
         hold_q <= lock_sel;
      end else if (start) begin
         hold_q <= 1'b0;
      end
   end
`else
   assign lock_sel = 1'b0;
   assign hold     = 1'b0;
`endif

   ula_rr_arb2 u_rr (
      .req0     (req0),
      .req1     (req1),
      .ptr      (ptr_q),
      .hold     (hold),
      .hold_sel (sel_q),
      .any      (any_req),
      .pick     (pick)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state and edge strobes
   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      capture    = 1'b0;
      release_op = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = EXEC;
               start   = 1'b1;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               capture = 1'b1;
            end
         end
         DONE: begin
            state_d    = IDLE;
            release_op = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Cycle counter: loaded on grant, counts down while operands sit on the ALU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == EXEC && cnt_q != '0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Owner select and last-served pointer; a held lock keeps the pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= 1'b0;
         ptr_q <= 1'b1;
      end else begin
         if (start) begin
            sel_q <= pick;
         end
         if (release_op && !lock_sel) begin
            ptr_q <= sel_q;
         end
      end
   end

   // Operand registers: only written when an operation is granted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q <= '0;
         fc_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (start) begin
         op_q <= pick ? op1 : op0;
         fc_q <= pick ? fc1 : fc0;
         a_q  <= pick ? a1  : a0;
         b_q  <= pick ? b1  : b0;
      end
   end

   // Result capture at the end of execution; held until the next capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else if (capture) begin
         result_q <= ula_out;
         zero_q   <= ula_zero;
      end
   end

   assign ula_op   = op_q;
   assign ula_fc   = fc_q;
   assign ula_a    = a_q;
   assign ula_b    = b_q;
   assign result   = result_q;
   assign res_zero = zero_q;
   assign gnt0     = (state_q != IDLE) && !sel_q;
   assign gnt1     = (state_q != IDLE) &&  sel_q;
   assign done0    = (state_q == DONE) && !sel_q;
   assign done1    = (state_q == DONE) &&  sel_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter. Two instances share stimulus:
// d1 with EXEC_CYCLES=1 and d4 with EXEC_CYCLES=4, each with its own ALU model.
module tb_ula_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [3:0]  op0, op1;
   logic [5:0]  fc0, fc1;
   logic [31:0] a0, b0, a1, b1;
   logic        lock0, lock1;

   logic        d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_res_zero, d1_ula_zero;
   logic [31:0] d1_result, d1_ula_a, d1_ula_b, d1_ula_out;
   logic [3:0]  d1_ula_op;
   logic [5:0]  d1_ula_fc;
   logic        d4_gnt0, d4_gnt1, d4_done0, d4_done1, d4_res_zero, d4_ula_zero;
   logic [31:0] d4_result, d4_ula_a, d4_ula_b, d4_ula_out;
   logic [3:0]  d4_ula_op;
   logic [5:0]  d4_ula_fc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: alu = a & b;
         4'b0001: alu = a | b;
         4'b0010: alu = a + b;
         4'b0110: alu = a - b;
         default: alu = 32'd0;
      endcase
   endfunction

   assign d1_ula_out  = alu(d1_ula_op, d1_ula_a, d1_ula_b);
   assign d1_ula_zero = (d1_ula_out == 32'd0);
   assign d4_ula_out  = alu(d4_ula_op, d4_ula_a, d4_ula_b);
   assign d4_ula_zero = (d4_ula_out == 32'd0);

   ula_arbiter #(.EXEC_CYCLES(1)) d1 (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .fc0(fc0), .fc1(fc1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
`ifdef ULA_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .gnt0(d1_gnt0), .gnt1(d1_gnt1), .done0(d1_done0), .done1(d1_done1),
      .result(d1_result), .res_zero(d1_res_zero), .ula_op(d1_ula_op), .ula_fc(d1_ula_fc),
      .ula_a(d1_ula_a), .ula_b(d1_ula_b), .ula_out(d1_ula_out), .ula_zero(d1_ula_zero)
   );

   ula_arbiter #(.EXEC_CYCLES(4)) d4 (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .fc0(fc0), .fc1(fc1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
`ifdef ULA_ARB_LOCK_EN
      .lock0(lock0), .lock1(lock1),
`endif
      .gnt0(d4_gnt0), .gnt1(d4_gnt1), .done0(d4_done0), .done1(d4_done1),
      .result(d4_result), .res_zero(d4_res_zero), .ula_op(d4_ula_op), .ula_fc(d4_ula_fc),
      .ula_a(d4_ula_a), .ula_b(d4_ula_b), .ula_out(d4_ula_out), .ula_zero(d4_ula_zero)
   );

   task automatic clear_inputs;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0; fc0 = 0; fc1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; lock0 = 0; lock1 = 0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      checks++; if (d1_gnt0 !== 1'b0 || d1_gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b%b exp=00", d1_gnt0, d1_gnt1); end
      checks++; if (d1_done0 !== 1'b0 || d1_done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", d1_done0, d1_done1); end
      checks++; if (d1_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", d1_result); end
      checks++; if (d1_res_zero !== 1'b1) begin failures++; $display("FAIL reset_res_zero got=%b exp=1", d1_res_zero); end
      checks++; if (d1_ula_a !== 32'd0 || d1_ula_b !== 32'd0 || d1_ula_op !== 4'd0 || d1_ula_fc !== 6'd0) begin
         failures++; $display("FAIL reset_operands got a=%0d b=%0d op=%0d fc=%0d exp=0", d1_ula_a, d1_ula_b, d1_ula_op, d1_ula_fc); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      req0 = 1; op0 = 4'b0010; fc0 = 6'h20; a0 = 32'd5; b0 = 32'd7;
      @(negedge clk);
      checks++; if (d1_gnt0 !== 1'b1 || d1_gnt1 !== 1'b0) begin failures++; $display("FAIL single_gnt got=%b%b exp=gnt0", d1_gnt0, d1_gnt1); end
      checks++; if (d1_done0 !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", d1_done0); end
      checks++; if (d1_ula_a !== 32'd5 || d1_ula_b !== 32'd7 || d1_ula_op !== 4'b0010 || d1_ula_fc !== 6'h20) begin
         failures++; $display("FAIL single_operands got a=%0d b=%0d op=%0d fc=%0h exp 5 7 2 20", d1_ula_a, d1_ula_b, d1_ula_op, d1_ula_fc); end
      req0 = 0;
      @(negedge clk);
      checks++; if (d1_done0 !== 1'b1 || d1_done1 !== 1'b0) begin failures++; $display("FAIL single_done got=%b%b exp=done0", d1_done0, d1_done1); end
      checks++; if (d1_result !== 32'd12) begin failures++; $display("FAIL single_result got=%0d exp=12", d1_result); end
      checks++; if (d1_res_zero !== 1'b0) begin failures++; $display("FAIL single_res_zero got=%b exp=0", d1_res_zero); end
      @(negedge clk);
      checks++; if (d1_done0 !== 1'b0 || d1_gnt0 !== 1'b0) begin failures++; $display("FAIL single_release got done0=%b gnt0=%b exp=0", d1_done0, d1_gnt0); end
      checks++; if (d1_result !== 32'd12) begin failures++; $display("FAIL single_result_hold got=%0d exp=12", d1_result); end
   endtask

   task automatic test_round_robin;
      int exp_who[3] = '{0, 1, 0};
      logic [31:0] exp_res[3] = '{32'd2, 32'd4, 32'd2};
      int when[3];
      int n = 0;
      rst_n = 1'b0;
      clear_inputs();
      req0 = 1; op0 = 4'b0010; a0 = 32'd1; b0 = 32'd1;
      req1 = 1; op1 = 4'b0010; a1 = 32'd2; b1 = 32'd2;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 20 && n < 3; c++) begin
         @(negedge clk);
         if (d1_done0 || d1_done1) begin
            checks++; if (d1_done0 && d1_done1) begin failures++; $display("FAIL rr_both_done got=11 exp=one-hot"); end
            checks++; if ((d1_done1 ? 1 : 0) !== exp_who[n]) begin failures++; $display("FAIL rr_order op%0d got=%0d exp=%0d", n, d1_done1 ? 1 : 0, exp_who[n]); end
            checks++; if (d1_result !== exp_res[n]) begin failures++; $display("FAIL rr_result op%0d got=%0d exp=%0d", n, d1_result, exp_res[n]); end
            when[n] = c;
            n++;
         end
      end
      checks++; if (n !== 3) begin failures++; $display("FAIL rr_timeout got=%0d dones exp=3", n); end
      else begin
         checks++; if (when[0] !== 2) begin failures++; $display("FAIL rr_first_latency got=%0d exp=2", when[0]); end
         checks++; if (when[1] - when[0] !== 3 || when[2] - when[1] !== 3) begin
            failures++; $display("FAIL rr_issue_rate got=%0d,%0d exp=3,3", when[1] - when[0], when[2] - when[1]); end
      end
      req0 = 0; req1 = 0;
   endtask

   task automatic test_drop_req;
      clear_inputs();
      repeat (4) @(negedge clk);
      req1 = 1; op1 = 4'b0110; a1 = 32'd9; b1 = 32'd9;
      @(negedge clk);
      checks++; if (d1_gnt1 !== 1'b1 || d1_gnt0 !== 1'b0) begin failures++; $display("FAIL drop_gnt got=%b%b exp=gnt1", d1_gnt0, d1_gnt1); end
      req1 = 0;
      @(negedge clk);
      checks++; if (d1_done1 !== 1'b1 || d1_done0 !== 1'b0) begin failures++; $display("FAIL drop_done got=%b%b exp=done1", d1_done0, d1_done1); end
      checks++; if (d1_result !== 32'd0 || d1_res_zero !== 1'b1) begin failures++; $display("FAIL drop_result got=%0d z=%b exp=0 z=1", d1_result, d1_res_zero); end
      @(negedge clk);
      checks++; if (d1_done1 !== 1'b0 || d1_gnt1 !== 1'b0) begin failures++; $display("FAIL drop_idle got done1=%b gnt1=%b exp=0", d1_done1, d1_gnt1); end
   endtask

   task automatic test_exec4;
      do_reset();
      req1 = 1; op1 = 4'b0010; fc1 = 6'h11; a1 = 32'd3; b1 = 32'd4;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++; if (d4_gnt1 !== 1'b1 || d4_done1 !== 1'b0) begin failures++; $display("FAIL exec4_busy c%0d got gnt1=%b done1=%b exp=1,0", k, d4_gnt1, d4_done1); end
         checks++; if (d4_ula_a !== 32'd3 || d4_ula_b !== 32'd4 || d4_ula_op !== 4'b0010 || d4_ula_fc !== 6'h11) begin
            failures++; $display("FAIL exec4_stable c%0d got a=%0d b=%0d op=%0d fc=%0h exp 3 4 2 11", k, d4_ula_a, d4_ula_b, d4_ula_op, d4_ula_fc); end
         req1 = 0; a1 = 32'd100; b1 = 32'd200;
      end
      @(negedge clk);
      checks++; if (d4_done1 !== 1'b1) begin failures++; $display("FAIL exec4_done got=%b exp=1", d4_done1); end
      checks++; if (d4_result !== 32'd7 || d4_res_zero !== 1'b0) begin failures++; $display("FAIL exec4_result got=%0d z=%b exp=7 z=0", d4_result, d4_res_zero); end
   endtask

   task automatic test_reset_mid_exec;
      int seen = 0;
      int lat  = 0;
      do_reset();
      req0 = 1; op0 = 4'b0010; a0 = 32'd10; b0 = 32'd20;
      @(negedge clk);
      req0 = 0;
      checks++; if (d4_gnt0 !== 1'b1) begin failures++; $display("FAIL midrst_gnt got=%b exp=1", d4_gnt0); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (d4_gnt0 !== 1'b0 || d4_done0 !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got gnt0=%b done0=%b exp=0", d4_gnt0, d4_done0); end
      checks++; if (d4_result !== 32'd0 || d4_res_zero !== 1'b1 || d4_ula_a !== 32'd0) begin
         failures++; $display("FAIL midrst_data got res=%0d z=%b a=%0d exp=0 1 0", d4_result, d4_res_zero, d4_ula_a); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (d4_done0) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d pulses exp=0", seen); end
      rst_n = 1'b1;
      req0 = 1;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         @(negedge clk);
         req0 = 0;
         if (d4_done0) lat = c;
      end
      checks++; if (lat !== 5) begin failures++; $display("FAIL midrst_resume_latency got=%0d exp=5", lat); end
      checks++; if (d4_result !== 32'd30) begin failures++; $display("FAIL midrst_resume_result got=%0d exp=30", d4_result); end
   endtask

`ifdef ULA_ARB_LOCK_EN
   task automatic test_lock;
      int exp_who[3] = '{0, 0, 1};
      int when[3];
      int n = 0;
      rst_n = 1'b0;
      clear_inputs();
      req0 = 1; op0 = 4'b0010; a0 = 32'd1; b0 = 32'd1;
      req1 = 1; op1 = 4'b0010; a1 = 32'd2; b1 = 32'd2;
      lock0 = 1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 20 && n < 3; c++) begin
         @(negedge clk);
         if (n >= 1 && c == when[0] + 1) lock0 = 0;
         if (d1_done0 || d1_done1) begin
            checks++; if ((d1_done1 ? 1 : 0) !== exp_who[n]) begin failures++; $display("FAIL lock_order op%0d got=%0d exp=%0d", n, d1_done1 ? 1 : 0, exp_who[n]); end
            when[n] = c;
            n++;
         end
      end
      checks++; if (n !== 3) begin failures++; $display("FAIL lock_timeout got=%0d dones exp=3", n); end
      clear_inputs();
   endtask
`endif

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_drop_req();
      test_exec4();
      test_reset_mid_exec();
`ifdef ULA_ARB_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
